fetch_stage: RTL

- Instruction fetch stage. Produces the instr/pc/ce stream consumed by the decode stage, and honours decode's stall.
- Owns the program counter.
- Issues single-outstanding requests to instruction memory using a req/ack handshake.
- Absorbs one in-flight response in a 1-entry skid buffer while stalled.
- Applies PC redirects from execute, and discards any stale response that is still in flight.

---
 rtl/fetch_stage.sv | 107 ++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC and runs a single-outstanding imem req/ack fetch with a 1-entry skid buffer.
// A redirect taken while a request is in flight parks its target until the stale ack is dropped.
module fetch_stage #(
    parameter int IWIDTH = 32,
    parameter int PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                f_clk,
    input  logic                f_rst,
    output logic                f_o_imem_req,
    output logic [PC_WIDTH-1:0] f_o_imem_addr,
    input  logic                f_i_imem_ack,
    input  logic [IWIDTH-1:0]   f_i_imem_data,
    input  logic                f_i_change_pc,
    input  logic [PC_WIDTH-1:0] f_i_new_pc,
    input  logic                f_i_stall,
    output logic [IWIDTH-1:0]   f_o_instr,
    output logic [PC_WIDTH-1:0] f_o_pc,
    output logic                f_o_ce
);
    typedef enum logic [1:0] {RST, FETCH, DISCARD} state_t;
    state_t state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d, pend_q, pend_d, opc_q, opc_d, skid_pc_q, skid_pc_d, target;
    logic [IWIDTH-1:0] instr_q, instr_d, skid_instr_q, skid_instr_d;
    logic ce_q, ce_d, skid_v_q, skid_v_d, req, accept;
    assign req = (state_q == FETCH && !skid_v_q) || state_q == DISCARD;
    assign accept = state_q == FETCH && req && f_i_imem_ack && !f_i_change_pc;
    assign target = f_i_new_pc & ~PC_WIDTH'(3);
    assign f_o_imem_req = req;
    assign f_o_imem_addr = pc_q;
    assign f_o_instr = instr_q;
    assign f_o_pc = opc_q;
    assign f_o_ce = ce_q;
    always_comb begin
        state_d = state_q;
        pc_d = pc_q;
        pend_d = pend_q;
        case (state_q)
            RST: begin
                state_d = FETCH;
                pc_d = f_i_change_pc ? target : pc_q;
            end
            FETCH: begin
                // the in-flight address must stay on the bus, so park the target instead
                if (f_i_change_pc && req && !f_i_imem_ack) begin
                    state_d = DISCARD;
                    pend_d = target;
                end else if (f_i_change_pc) pc_d = target;
                else if (accept) pc_d = pc_q + PC_WIDTH'(4);
            end
            DISCARD: begin
                state_d = f_i_imem_ack ? FETCH : DISCARD;
                pend_d = f_i_change_pc ? target : pend_q;
                pc_d = f_i_imem_ack ? pend_d : pc_q;
            end
            default: state_d = RST;
        endcase
    end
    always_comb begin
        instr_d = instr_q;
        opc_d = opc_q;
        ce_d = ce_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d = skid_pc_q;
        skid_v_d = skid_v_q;
        if (f_i_change_pc) begin
            ce_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (accept && f_i_stall && ce_q) begin
            skid_instr_d = f_i_imem_data;
            skid_pc_d = pc_q;
            skid_v_d = 1'b1;
        end else if (accept) begin
            instr_d = f_i_imem_data;
            opc_d = pc_q;
            ce_d = 1'b1;
        end else if (!f_i_stall) begin
            instr_d = skid_v_q ? skid_instr_q : instr_q;
            opc_d = skid_v_q ? skid_pc_q : opc_q;
            ce_d = skid_v_q;
            skid_v_d = 1'b0;
        end
    end
    always_ff @(posedge f_clk) begin
        if (f_rst) begin
            state_q <= RST;
            pc_q <= RESET_PC;
            pend_q <= '0;
            instr_q <= '0;
            opc_q <= '0;
            ce_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q <= '0;
            skid_v_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            pend_q <= pend_d;
            instr_q <= instr_d;
            opc_q <= opc_d;
            ce_q <= ce_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q <= skid_pc_d;
            skid_v_q <= skid_v_d;
        end
    end
endmodule
